id_ex_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 27 ++
 rtl/id_ex_bypass_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 117 +++++++++++
 tb/tb_id_ex_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: decoded control bundle, ALU op classes, register 0.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       aluSrc;
    logic       regDst;
    logic [1:0] aluOp;
  } ctrl_t;

  // A slot without a real instruction must never carry side-effecting control.
  function automatic ctrl_t ctrl_bubble(input ctrl_t c, input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/id_ex_bypass_mux.sv
// Per-operand writeback bypass select; active only when WB_BYPASS_EN is defined,
// otherwise it passes the captured/held value straight through.
module id_ex_bypass_mux
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0]     base,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regWrite,
  input  logic [DATA_W-1:0]     wb_write_data,
  output logic [DATA_W-1:0]     sel_data
);

`ifdef WB_BYPASS_EN
  logic hit;

  assign hit      = wb_regWrite && (wb_rd != REG_ADDR_W'(REG_ZERO)) && (wb_rd == idx);
  assign sel_data = hit ? wb_write_data : base;
`else
  logic unused_wb;

  assign unused_wb = ^{idx, wb_rd, wb_regWrite, wb_write_data};
  assign sel_data  = base;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and bubble handling.
// Optional writeback bypass into A/B is enabled by defining WB_BYPASS_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_regWrite,
  input  logic                  id_memToReg,
  input  logic                  id_memRead,
  input  logic                  id_memWrite,
  input  logic                  id_branch,
  input  logic                  id_aluSrc,
  input  logic                  id_regDst,
  input  logic [1:0]            id_aluOp,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  wb_regWrite,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_A,
  output logic [DATA_W-1:0]     ex_B,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_regWrite,
  output logic                  ex_memToReg,
  output logic                  ex_memRead,
  output logic                  ex_memWrite,
  output logic                  ex_branch,
  output logic                  ex_aluSrc,
  output logic [1:0]            ex_aluOp
);

  ctrl_t                 id_ctrl;
  ctrl_t                 ld_ctrl;
  logic [REG_ADDR_W-1:0] a_idx, b_idx;
  logic [DATA_W-1:0]     a_base, b_base;
  logic [DATA_W-1:0]     a_sel, b_sel;

  assign id_ctrl = '{regWrite: id_regWrite, memToReg: id_memToReg, memRead: id_memRead,
                     memWrite: id_memWrite, branch: id_branch, aluSrc: id_aluSrc,
                     regDst: id_regDst, aluOp: id_aluOp};
  assign ld_ctrl = ctrl_bubble(id_ctrl, id_valid);

  // While stalled the bypass compares against the held indices and patches the held operands.
  assign a_idx  = stall ? ex_rs : rs;
  assign b_idx  = stall ? ex_rt : rt;
  assign a_base = stall ? ex_A  : A;
  assign b_base = stall ? ex_B  : B;

  id_ex_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_byp_a (
    .idx(a_idx), .base(a_base), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .wb_write_data(wb_write_data), .sel_data(a_sel)
  );

  id_ex_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_byp_b (
    .idx(b_idx), .base(b_base), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .wb_write_data(wb_write_data), .sel_data(b_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      if (!rst_n || flush) begin
        ex_valid    <= 1'b0;
        ex_pc_plus4 <= '0;
        ex_A        <= '0;
        ex_B        <= '0;
        ex_imm      <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_dest     <= '0;
        ex_regWrite <= 1'b0;
        ex_memToReg <= 1'b0;
        ex_memRead  <= 1'b0;
        ex_memWrite <= 1'b0;
        ex_branch   <= 1'b0;
        ex_aluSrc   <= 1'b0;
        ex_aluOp    <= 2'b00;
      end
    end else if (stall) begin
      ex_A <= a_sel;
      ex_B <= b_sel;
    end else begin
      ex_valid    <= id_valid;
      ex_pc_plus4 <= id_pc_plus4;
      ex_A        <= a_sel;
      ex_B        <= b_sel;
      ex_imm      <= id_imm;
      ex_rs       <= rs;
      ex_rt       <= rt;
      ex_dest     <= id_ctrl.regDst ? rd : rt;
      ex_regWrite <= ld_ctrl.regWrite;
      ex_memToReg <= ld_ctrl.memToReg;
      ex_memRead  <= ld_ctrl.memRead;
      ex_memWrite <= ld_ctrl.memWrite;
      ex_branch   <= ld_ctrl.branch;
      ex_aluSrc   <= ld_ctrl.aluSrc;
      ex_aluOp    <= ld_ctrl.aluOp;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a rule-level reference model.
module tb_id_ex_stage;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_pc_plus4, A, B, id_imm, wb_write_data;
  logic [4:0]  rs, rt, rd, wb_rd;
  logic        id_regWrite, id_memToReg, id_memRead, id_memWrite, id_branch, id_aluSrc, id_regDst;
  logic [1:0]  id_aluOp;
  logic        wb_regWrite;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_A, ex_B, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic        ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_branch, ex_aluSrc;
  logic [1:0]  ex_aluOp;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_pc, m_A, m_B, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [7:0]  m_ctrl;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc_plus4(id_pc_plus4), .rs(rs), .rt(rt), .rd(rd), .A(A), .B(B), .id_imm(id_imm),
    .id_regWrite(id_regWrite), .id_memToReg(id_memToReg), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_branch(id_branch), .id_aluSrc(id_aluSrc),
    .id_regDst(id_regDst), .id_aluOp(id_aluOp), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
    .wb_regWrite(wb_regWrite), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_A(ex_A),
    .ex_B(ex_B), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_branch(ex_branch), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp)
  );

  function automatic logic [151:0] dut_vec();
    return {ex_valid, ex_pc_plus4, ex_A, ex_B, ex_imm, ex_rs, ex_rt, ex_dest,
            ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_branch, ex_aluSrc, ex_aluOp};
  endfunction

  function automatic logic [151:0] exp_vec();
    return {m_valid, m_pc, m_A, m_B, m_imm, m_rs, m_rt, m_dest, m_ctrl};
  endfunction

  function automatic bit wb_hits(input logic [4:0] idx);
    return BYP && wb_regWrite && (wb_rd != 5'd0) && (wb_rd == idx);
  endfunction

  task automatic model_zero();
    m_valid = 0; m_pc = 0; m_A = 0; m_B = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_dest = 0; m_ctrl = 0;
  endtask

  // Applies one rising edge worth of the stage's rules to the model.
  task automatic model_clock();
    if (flush) model_zero();
    else if (stall) begin
      if (wb_hits(m_rs)) m_A = wb_write_data;
      if (wb_hits(m_rt)) m_B = wb_write_data;
    end else begin
      m_valid = id_valid;
      m_pc    = id_pc_plus4;
      m_A     = wb_hits(rs) ? wb_write_data : A;
      m_B     = wb_hits(rt) ? wb_write_data : B;
      m_imm   = id_imm;
      m_rs    = rs;
      m_rt    = rt;
      m_dest  = id_regDst ? rd : rt;
      m_ctrl  = id_valid ? {id_regWrite, id_memToReg, id_memRead, id_memWrite,
                            id_branch, id_aluSrc, id_aluOp} : 8'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic rand_inputs();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_pc_plus4 = $urandom;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom);
    A = $urandom; B = $urandom; id_imm = $urandom;
    {id_regWrite, id_memToReg, id_memRead, id_memWrite, id_branch, id_aluSrc, id_regDst} = 7'($urandom);
    id_aluOp      = 2'($urandom);
    wb_rd         = 5'($urandom_range(0, 7));
    wb_write_data = $urandom;
    wb_regWrite   = $urandom_range(0, 1) != 0;
  endtask

  task automatic clear_ctl();
    stall = 0; flush = 0; wb_regWrite = 0; wb_rd = 0; wb_write_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_ctl(); rand_inputs(); wb_regWrite = 0;
    model_zero();
    #3;
    checks++;
    if (dut_vec() !== 152'd0) begin
      errors++; $display("FAIL reset_initial got %h want 0", dut_vec());
    end
    @(posedge clk); #1;
    checks++;
    if (dut_vec() !== 152'd0) begin
      errors++; $display("FAIL reset_held_over_edge got %h want 0", dut_vec());
    end
    rst_n = 1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_first_load got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    clear_ctl(); rand_inputs(); id_valid = 1; id_regWrite = 1;
    tick();
    stall = 1; flush = 1;
    #2 rst_n = 0; model_zero();
    #1;
    checks++;
    if (dut_vec() !== 152'd0) begin
      errors++; $display("FAIL mid_reset_async got %h want 0", dut_vec());
    end
    @(posedge clk); #3;
    rst_n = 1; stall = 0; flush = 0;
    #1;
    checks++;
    if (dut_vec() !== 152'd0) begin
      errors++; $display("FAIL mid_reset_before_edge got %h want 0", dut_vec());
    end
    tick();
    checks++;
    if (dut_vec() !== exp_vec() || ex_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reset_release_load got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_load();
    clear_ctl(); rand_inputs(); wb_regWrite = 0;
    id_valid = 1; rs = 5; A = 32'hA5A5A5A5; id_regDst = 1; rd = 10; rt = 3;
    tick();
    checks++;
    if (ex_A !== 32'hA5A5A5A5 || ex_dest !== 5'd10) begin
      errors++; $display("FAIL load_regdst1 got A=%h dest=%0d want A=a5a5a5a5 dest=10", ex_A, ex_dest);
    end
    id_regDst = 0;
    tick();
    checks++;
    if (ex_dest !== 5'd3 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL load_regdst0 got dest=%0d vec=%h want dest=3 vec=%h", ex_dest, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_bubble();
    clear_ctl(); rand_inputs(); wb_regWrite = 0;
    id_valid = 0;
    {id_regWrite, id_memToReg, id_memRead, id_memWrite, id_branch, id_aluSrc} = 6'h3f;
    id_aluOp = 2'b11;
    tick();
    checks++;
    if ({ex_valid, ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_branch, ex_aluSrc, ex_aluOp} !== 9'd0
        || ex_imm !== id_imm) begin
      errors++; $display("FAIL bubble_ctrl got %h want ctrl 0 imm %h", dut_vec(), id_imm);
    end
  endtask

  task automatic test_stall();
    logic [151:0] frozen;
    clear_ctl(); rand_inputs(); id_valid = 1; wb_regWrite = 0;
    tick();
    frozen = dut_vec();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); wb_regWrite = 0;
      tick();
      checks++;
      if (dut_vec() !== frozen) begin
        errors++; $display("FAIL stall_hold_%0d got %h want %h", i, dut_vec(), frozen);
      end
    end
    stall = 0;
  endtask

  task automatic test_flush_stall();
    clear_ctl(); rand_inputs(); id_valid = 1; id_regWrite = 1;
    tick();
    rand_inputs(); id_valid = 1; id_regWrite = 1;
    stall = 1; flush = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || dut_vec() !== 152'd0) begin
      errors++; $display("FAIL flush_over_stall got %h want 0", dut_vec());
    end
    clear_ctl();
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    clear_ctl(); rand_inputs();
    rs = 10; rt = 10; A = 0; B = 0;
    wb_rd = 10; wb_write_data = 32'h12345678; wb_regWrite = 1;
    tick();
    want = BYP ? 32'h12345678 : 32'h0;
    checks++;
    if (ex_A !== want || ex_B !== want) begin
      errors++; $display("FAIL bypass_load got A=%h B=%h want %h", ex_A, ex_B, want);
    end
    wb_rd = 0;
    tick();
    checks++;
    if (ex_A !== 32'h0 || ex_B !== 32'h0) begin
      errors++; $display("FAIL bypass_rd0 got A=%h B=%h want 0", ex_A, ex_B);
    end
  endtask

  task automatic test_stall_bypass();
    logic [31:0] want;
    clear_ctl(); rand_inputs(); wb_regWrite = 0;
    rs = 7; rt = 2; A = 32'h11111111; B = 32'h22222222;
    tick();
    stall = 1; wb_rd = 7; wb_write_data = 32'hDEADBEEF; wb_regWrite = 1;
    tick();
    want = BYP ? 32'hDEADBEEF : 32'h11111111;
    checks++;
    if (ex_A !== want || ex_B !== 32'h22222222) begin
      errors++; $display("FAIL stall_bypass got A=%h B=%h want A=%h B=22222222", ex_A, ex_B, want);
    end
    wb_rd = 2; wb_write_data = 32'hCAFEF00D; flush = 1;
    tick();
    checks++;
    if (ex_A !== 32'h0 || ex_B !== 32'h0) begin
      errors++; $display("FAIL flush_ignores_bypass got A=%h B=%h want 0", ex_A, ex_B);
    end
    clear_ctl();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    clear_ctl();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bubble();
    test_stall();
    test_flush_stall();
    test_bypass();
    test_stall_bypass();
    test_random();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
